udp_payload_pingpong: RTL
=========================

Name: udp_payload_pingpong

Overview:
- Parametrised successor to the single-bank UDP payload RAM and its default-data loader.
- After reset, the block preloads a default payload into bank 0.
- Received UDP payloads are captured into the inactive bank; each committed frame swaps banks atomically, but only while the transmitter is idle.
- The TX engine always reads a complete, stable payload and is given matching length fields. The block sits between the udp core's RX write port and its TX read port, in the clk_125 domain.

Parameters:
- DATA_W, 32, payload word width in bits.
- ADDR_W, 9, address width per bank; bank depth is 2**ADDR_W words.
- INIT_WORDS, 5, number of default payload words preloaded. Legal range is 1..2**ADDR_W-INIT_BASE.
- INIT_BASE, 1, bank-0 address of the first default word.
- INIT_DATA, "HELLO QMTECH BOARD\n\r" packed, flattened DATA_W*INIT_WORDS vector. Word k is bits [DATA_W*(INIT_WORDS-k)-1 -: DATA_W], so word 0 is the MSBs.
- DEF_DATA_LEN, 16'd28, UDP length reported before the first committed frame.
- DEF_IP_LEN, 16'd48, IP total length reported before the first committed frame.

Ports:
- clk  in  1  clk_125; every register in the block is clocked on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rx_wr_en  in  1  RX payload word write strobe.
- rx_wr_addr  in  ADDR_W  write address in the fill bank.
- rx_wr_data  in  DATA_W  RX payload word.
- rx_frame_done  in  1  single-cycle pulse: the frame is good, commit it.
- rx_frame_abort  in  1  single-cycle pulse: the frame is bad, discard it.
- rx_data_len  in  16  UDP length; sampled on rx_frame_done.
- rx_ip_len  in  16  IP total length; sampled on rx_frame_done.
- tx_busy  in  1  high while the TX engine reads the display bank.
- tx_rd_addr  in  ADDR_W  read address in the display bank.
- tx_rd_data  out  DATA_W  registered read data.
- tx_data_len  out  16  UDP length for the display bank.
- tx_ip_len  out  16  IP total length for the display bank.
- init_done  out  1  high once the preload has finished.
- frame_valid  out  1  sticky: at least one RX frame has been displayed.
- swap_pending  out  1  a commit is waiting for tx_busy to fall.
- rx_dropped  out  1  sticky: an RX write or commit was discarded.

Behaviour:
- Reset values:
  - FSM goes to INIT; load counter = 0.
  - disp_bank = 0 (fill bank is always ~disp_bank).
  - tx_rd_data = 0.
  - tx_data_len = DEF_DATA_LEN; tx_ip_len = DEF_IP_LEN.
  - init_done, frame_valid, swap_pending and rx_dropped = 0.
  - Applies in any state, including mid-preload and mid-swap. RAM contents are not cleared.
- FSM states: INIT, RUN, PEND.
- INIT:
  - Each cycle, write INIT_DATA word k to bank 0 at address INIT_BASE+k, then k++.
  - After word INIT_WORDS-1, go to RUN and set init_done on the next edge. Total INIT time is exactly INIT_WORDS cycles.
  - RX writes, commits and aborts in INIT are ignored and set rx_dropped.
- RUN:
  - rx_wr_en writes rx_wr_data to fill-bank address rx_wr_addr.
  - rx_frame_done with tx_busy=0: on the same edge, toggle disp_bank, latch rx_data_len/rx_ip_len into tx_data_len/tx_ip_len, and set frame_valid.
  - rx_frame_done with tx_busy=1: latch the lengths into a shadow register, go to PEND, set swap_pending.
  - rx_frame_abort: no swap and no length change. The fill bank is reused as scratch.
  - rx_frame_done and rx_frame_abort asserted together: abort wins.
- PEND:
  - The fill bank is frozen. rx_wr_en and rx_frame_done are ignored and set rx_dropped; rx_frame_abort is ignored silently.
  - On the first cycle with tx_busy=0: toggle disp_bank, copy the shadow lengths to the outputs, set frame_valid, clear swap_pending, return to RUN.
- Read path:
  - tx_rd_data = display_bank[tx_rd_addr], one cycle of latency.
  - The bank is selected by disp_bank as registered in the address cycle. A read in the swap cycle returns old-bank data.
- The TX engine must assert tx_busy before its first read and hold it through its last read.
- tx_data_len/tx_ip_len change only on the edge where disp_bank toggles, never otherwise.
- Lengths are passed through unchecked: no clamp, no arithmetic.
- A read or write address beyond the loaded or written data returns stale contents; this is not an error.

Decomposition:
- Shared header udp_pkg.vh holds:
  - FSM state encodings ST_INIT=2'd0, ST_RUN=2'd1, ST_PEND=2'd2.
  - Length defaults UDP_DEF_DATA_LEN and UDP_DEF_IP_LEN.
- One sub-module, udp_bank_ram:
  - Simple dual-port RAM, depth 2**(ADDR_W+1), address {bank, addr}.
  - Synchronous write and registered read on clk; infers M9K.
- Top-level logic holds the FSM, load counter, bank pointer, shadow lengths, write mux (INIT vs RX) and status flags.

Test Plan:
- Release reset, then read addresses 1..5 with tx_busy=1 -> data 0x48454C4C, 0x4F20514D, 0x54454348, 0x20424F41, 0x52440A0D.
- Same run -> init_done rises exactly 5 cycles after reset_n=1; tx_data_len=28, tx_ip_len=48.
- tx_busy=0: write 0xDEADBEEF at address 0, then pulse rx_frame_done with rx_data_len=12, rx_ip_len=32 -> next cycle the lengths are 12/32, frame_valid=1, and a read of address 0 returns 0xDEADBEEF.
- tx_busy=1 during rx_frame_done -> swap_pending=1, lengths unchanged, and a later rx_wr_en sets rx_dropped. When tx_busy falls, the swap completes in 1 cycle and swap_pending=0.
- Write a frame, then pulse rx_frame_abort, or done+abort together -> disp_bank, lengths and frame_valid unchanged.
- Assert reset_n=0 at cycle 3 of INIT, then release -> INIT restarts at k=0, all 5 words are correct, and all flags are 0.

Source files
------------

// File: rtl/udp_payload_pingpong_pkg.sv
// udp_payload_pingpong_pkg: shared FSM state encodings and default UDP/IP lengths
package udp_payload_pingpong_pkg;
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;
    localparam logic [15:0] UDP_DEF_DATA_LEN = 16'd28;
    localparam logic [15:0] UDP_DEF_IP_LEN   = 16'd48;
endpackage

// File: rtl/udp_bank_ram.sv
// udp_bank_ram: simple dual-port RAM holding both payload banks, address {bank, addr}
// Ports: clk; reset_n clears only the read register; wr_en/wr_addr/wr_data write port;
//        rd_addr/rd_data registered read port (one cycle latency).
module udp_bank_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        rd_data <= !reset_n ? '0 : mem[rd_addr];
    end
endmodule

// File: rtl/udp_payload_pingpong.sv
// udp_payload_pingpong: ping-pong UDP payload store with default preload and TX-safe bank swap
// Ports: clk/reset_n (sync, active-low); rx_* RX write port, commit/abort pulses and lengths;
//        tx_busy/tx_rd_addr/tx_rd_data TX read port; tx_data_len/tx_ip_len lengths of the
//        display bank; init_done, frame_valid, swap_pending, rx_dropped status flags.
module udp_payload_pingpong
    import udp_payload_pingpong_pkg::*;
#(
    parameter int                         DATA_W       = 32,
    parameter int                         ADDR_W       = 9,
    parameter int                         INIT_WORDS   = 5,
    parameter int                         INIT_BASE    = 1,
    parameter logic [DATA_W*INIT_WORDS-1:0] INIT_DATA  = "HELLO QMTECH BOARD\n\r",
    parameter logic [15:0]                DEF_DATA_LEN = UDP_DEF_DATA_LEN,
    parameter logic [15:0]                DEF_IP_LEN   = UDP_DEF_IP_LEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_wr_en,
    input  logic [ADDR_W-1:0] rx_wr_addr,
    input  logic [DATA_W-1:0] rx_wr_data,
    input  logic              rx_frame_done,
    input  logic              rx_frame_abort,
    input  logic [15:0]       rx_data_len,
    input  logic [15:0]       rx_ip_len,
    input  logic              tx_busy,
    input  logic [ADDR_W-1:0] tx_rd_addr,
    output logic [DATA_W-1:0] tx_rd_data,
    output logic [15:0]       tx_data_len,
    output logic [15:0]       tx_ip_len,
    output logic              init_done,
    output logic              frame_valid,
    output logic              swap_pending,
    output logic              rx_dropped
);
    state_t            state, nstate;
    logic [ADDR_W-1:0] k;
    logic              disp_bank;
    logic [15:0]       sh_data_len, sh_ip_len;
    logic              swap, hold, drop, use_sh;
    logic              commit;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [DATA_W-1:0] wr_data, init_word;

    // abort overrides a simultaneous done
    assign commit = rx_frame_done & ~rx_frame_abort;

    always_comb begin
        nstate = state;
        swap   = 1'b0;
        hold   = 1'b0;
        drop   = 1'b0;
        use_sh = 1'b0;
        case (state)
            ST_INIT: begin
                nstate = (k == ADDR_W'(INIT_WORDS - 1)) ? ST_RUN : ST_INIT;
                drop   = rx_wr_en | rx_frame_done | rx_frame_abort;
            end
            ST_RUN: begin
                swap   = commit & ~tx_busy;
                hold   = commit & tx_busy;
                nstate = hold ? ST_PEND : ST_RUN;
            end
            ST_PEND: begin
                drop   = rx_wr_en | rx_frame_done;
                swap   = ~tx_busy;
                use_sh = 1'b1;
                nstate = tx_busy ? ST_PEND : ST_RUN;
            end
            default: nstate = ST_INIT;
        endcase
    end

    always_comb begin
        init_word = INIT_DATA[DATA_W*(INIT_WORDS-1-int'(k)) +: DATA_W];
        wr_en     = (state == ST_INIT) | ((state == ST_RUN) & rx_wr_en);
        wr_addr   = (state == ST_INIT) ? {1'b0, ADDR_W'(INIT_BASE) + k} : {~disp_bank, rx_wr_addr};
        wr_data   = (state == ST_INIT) ? init_word : rx_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_INIT;
            k            <= '0;
            disp_bank    <= 1'b0;
            tx_data_len  <= DEF_DATA_LEN;
            tx_ip_len    <= DEF_IP_LEN;
            init_done    <= 1'b0;
            frame_valid  <= 1'b0;
            swap_pending <= 1'b0;
            rx_dropped   <= 1'b0;
        end else begin
            state        <= nstate;
            k            <= (state == ST_INIT) ? k + 1'b1 : k;
            init_done    <= init_done | (nstate == ST_RUN);
            swap_pending <= (nstate == ST_PEND);
            rx_dropped   <= rx_dropped | drop;
            if (swap) begin
                disp_bank   <= ~disp_bank;
                tx_data_len <= use_sh ? sh_data_len : rx_data_len;
                tx_ip_len   <= use_sh ? sh_ip_len : rx_ip_len;
                frame_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hold) begin
            sh_data_len <= rx_data_len;
            sh_ip_len   <= rx_ip_len;
        end
    end

    udp_bank_ram #(.DATA_W(DATA_W), .AW(ADDR_W + 1)) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr ({disp_bank, tx_rd_addr}),
        .rd_data (tx_rd_data)
    );
endmodule
